// File: rtl/msrv32_pkg.sv
`default_nettype none
// msrv32_pkg -- shared constants and types for the msrv32 instruction-fetch unit.
// Revision: 1.0
package msrv32_pkg;

  localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int unsigned IFB_ENTRY_W = 65;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_RUN   = 2'd1,
    IF_FAULT = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } ifetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/msrv32_ifetch_buf.sv
`default_nettype none
// msrv32_ifetch_buf -- 2-entry fetch FIFO {instr, pc, fault}; head shown on rdata_o.
// Revision: 1.0
module msrv32_ifetch_buf
  import msrv32_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [IFB_ENTRY_W-1:0] wdata_i,
  output logic [IFB_ENTRY_W-1:0] rdata_o,
  output logic [1:0]             count_o
);

  logic [IFB_ENTRY_W-1:0] mem_q [2];
  logic                   wptr_q, wptr_d;
  logic                   rptr_q, rptr_d;
  logic [1:0]             count_q, count_d;
  logic                   do_push;
  logic                   do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (do_push) wptr_d = ~wptr_q;
      if (do_pop)  rptr_d = ~rptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/msrv32_ifetch.sv
`default_nettype none
// msrv32_ifetch -- AHB-lite instruction fetch: pipelined address/data phases, 2-entry buffer, flush/fault.
// Revision: 1.0
module msrv32_ifetch
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT
) (
  input  logic        msrv32_mp_clk_in,
  input  logic        msrv32_mp_rst_n_in,
  input  logic [31:0] iaddr_in,
  input  logic        flush_in,
  input  logic        stall_in,
  input  logic        ahb_ready_in,
  input  logic [31:0] ahb_rdata_in,
  input  logic        ahb_resp_in,
  output logic [1:0]  ahb_htrans_out,
  output logic [31:0] ahb_haddr_out,
  output logic [31:0] pc_out,
  output logic        pc_advance_out,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_fault_out
);

  ifetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   dph_pc_q, dph_pc_d;
  logic          dph_open_q, dph_open_d;
  logic          discard_q, discard_d;
  logic          hold_q, hold_d;

  logic          accept;
  logic          pop;
  logic          push;
  logic          room;
  logic [2:0]    inflight;
  logic [1:0]    count;
  ifetch_entry_t push_entry;
  ifetch_entry_t head_entry;
  logic [IFB_ENTRY_W-1:0] head_bits;

  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
    if (!msrv32_mp_rst_n_in) begin
      state_q <= IF_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_BOOT:  state_d = IF_RUN;
      IF_RUN:   if (push && ahb_resp_in) state_d = IF_FAULT;
      IF_FAULT: state_d = IF_FAULT;
      default:  state_d = IF_BOOT;
    endcase
    if (flush_in) state_d = IF_RUN;
  end

  // Issue only while buffered + in-flight work leaves a free slot; an unaccepted NONSEQ is always held.
  always_comb begin
    inflight       = {1'b0, count} - {2'b00, pop} + {2'b00, dph_open_q};
    room           = (inflight < 3'd2);
    ahb_htrans_out = HTRANS_IDLE;
    if (hold_q || ((state_q == IF_RUN) && room)) ahb_htrans_out = HTRANS_NONSEQ;
  end

  assign accept = (ahb_htrans_out == HTRANS_NONSEQ) && ahb_ready_in;
  assign pop    = instr_valid_out && !stall_in;
  assign push   = dph_open_q && ahb_ready_in && !discard_q && !flush_in;

  always_comb begin
    pc_d       = (accept || flush_in) ? iaddr_in : pc_q;
    dph_pc_d   = accept ? pc_q : dph_pc_q;
    dph_open_d = accept || (dph_open_q && !ahb_ready_in);
    hold_d     = (ahb_htrans_out == HTRANS_NONSEQ) && !ahb_ready_in;
    if (accept) begin
      discard_d = flush_in;
    end else if (dph_open_q && !ahb_ready_in) begin
      discard_d = discard_q || flush_in;
    end else begin
      discard_d = 1'b0;
    end
  end

  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
    if (!msrv32_mp_rst_n_in) begin
      pc_q       <= BOOT_ADDRESS;
      dph_pc_q   <= 32'h0000_0000;
      dph_open_q <= 1'b0;
      discard_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      dph_pc_q   <= dph_pc_d;
      dph_open_q <= dph_open_d;
      discard_q  <= discard_d;
      hold_q     <= hold_d;
    end
  end

  assign push_entry = {ahb_rdata_in, dph_pc_q, ahb_resp_in};

  msrv32_ifetch_buf u_buf (
    .clk_i   (msrv32_mp_clk_in),
    .rst_ni  (msrv32_mp_rst_n_in),
    .clear_i (flush_in),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_bits),
    .count_o (count)
  );

  assign head_entry      = head_bits;
  assign instr_valid_out = (count != 2'd0);
  assign instr_out       = head_entry.instr;
  assign instr_pc_out    = head_entry.pc;
  assign instr_fault_out = head_entry.fault;
  assign pc_out          = pc_q;
  assign ahb_haddr_out   = pc_q;
  assign pc_advance_out  = accept;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_ifetch.sv
`default_nettype none
// tb_msrv32_ifetch -- directed scenarios plus randomized AHB/decode traffic against an in-order stream model.
// Revision: 1.0
module tb_msrv32_ifetch;
  import msrv32_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iaddr;
  logic        flush, stall, ready, resp;
  logic [31:0] rdata, flush_tgt;
  logic [1:0]  htrans;
  logic [31:0] haddr, pc_out, instr, ipc;
  logic        adv, ivalid, ifault;

  int n_chk = 0;
  int n_fail = 0;
  int n_pops = 0;

  logic [31:0] exp_pc, exp_pc_out, prev_haddr, sl_addr, err_addr, data_xor;
  logic        pc_chk_valid, prev_wait, prev_flush, fault_seen, sl_open, err_rand_en;
  logic        found;

  always #5 clk = ~clk;

  // The bench plays the PC-select stage: sequential +4, or the redirect target on flush.
  assign iaddr = flush ? flush_tgt : pc_out + 32'd4;

  msrv32_ifetch #(.BOOT_ADDRESS(BOOT)) dut (
    .msrv32_mp_clk_in   (clk),
    .msrv32_mp_rst_n_in (rst_n),
    .iaddr_in           (iaddr),
    .flush_in           (flush),
    .stall_in           (stall),
    .ahb_ready_in       (ready),
    .ahb_rdata_in       (rdata),
    .ahb_resp_in        (resp),
    .ahb_htrans_out     (htrans),
    .ahb_haddr_out      (haddr),
    .pc_out             (pc_out),
    .pc_advance_out     (adv),
    .instr_valid_out    (ivalid),
    .instr_out          (instr),
    .instr_pc_out       (ipc),
    .instr_fault_out    (ifault)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ data_xor;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (a == err_addr) || (err_rand_en && (a[6:2] == 5'h13));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample, check, advance the model.
  task automatic step(input logic rdy, input logic stl, input logic fls, input logic [31:0] tgt);
    logic acc;
    @(negedge clk);
    ready     = rdy;
    stall     = stl;
    flush     = fls;
    flush_tgt = tgt;
    rdata     = sl_open ? data_of(sl_addr) : 32'hDEAD_BEEF;
    resp      = sl_open && err_of(sl_addr);
    #1;
    check_eq("haddr_eq_pc", haddr, pc_out);
    check_eq("pc_advance", {31'd0, adv}, {31'd0, (htrans == HTRANS_NONSEQ) && rdy});
    if (pc_chk_valid) check_eq("pc_out", pc_out, exp_pc_out);
    if (prev_wait) begin
      check_eq("hold_htrans", {30'd0, htrans}, {30'd0, HTRANS_NONSEQ});
      if (!prev_flush) check_eq("hold_addr", haddr, prev_haddr);
    end
    if (fault_seen) check_eq("fault_idle", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
    if (ivalid && !stl && !fls) begin
      check_eq("instr_pc", ipc, exp_pc);
      check_eq("instr", instr, data_of(exp_pc));
      check_eq("instr_fault", {31'd0, ifault}, {31'd0, err_of(exp_pc)});
      if (err_of(exp_pc)) fault_seen = 1'b1;
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
    acc          = (htrans == HTRANS_NONSEQ) && rdy;
    exp_pc_out   = fls ? tgt : (acc ? pc_out + 32'd4 : pc_out);
    pc_chk_valid = 1'b1;
    prev_wait    = (htrans == HTRANS_NONSEQ) && !rdy;
    prev_haddr   = haddr;
    prev_flush   = fls;
    if (fls) begin
      exp_pc     = tgt;
      fault_seen = 1'b0;
    end
    if (rdy) sl_open = 1'b0;
    if (acc) begin
      sl_open = 1'b1;
      sl_addr = haddr;
    end
  endtask

  // Reset is asserted and released away from the clock edge so only an asynchronous reset clears outputs early.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    ready = 1'b1;
    resp  = 1'b0;
    #1;
    check_eq("rst_htrans", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
    check_eq("rst_pc", pc_out, BOOT);
    check_eq("rst_adv", {31'd0, adv}, 32'd0);
    check_eq("rst_valid", {31'd0, ivalid}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_instr_pc", ipc, 32'd0);
    check_eq("rst_fault", {31'd0, ifault}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n        = 1'b1;
    exp_pc       = BOOT;
    exp_pc_out   = BOOT;
    pc_chk_valid = 1'b1;
    prev_wait    = 1'b0;
    prev_flush   = 1'b0;
    fault_seen   = 1'b0;
    sl_open      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; ready = 1'b1; resp = 1'b0;
    rdata = 32'd0; flush_tgt = 32'd0; sl_addr = 32'd0; prev_haddr = 32'd0;
    exp_pc = BOOT; exp_pc_out = BOOT; pc_chk_valid = 1'b0; prev_wait = 1'b0;
    prev_flush = 1'b0; fault_seen = 1'b0; sl_open = 1'b0;
    data_xor = 32'd0; err_addr = 32'hFFFF_FFFF; err_rand_en = 1'b0; found = 1'b0;

    // Zero wait states, rdata = address: boot cycle, then 0,4,8 with 2-cycle latency.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("boot_idle", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
    check_eq("boot_valid", {31'd0, ivalid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("c1_htrans", {30'd0, htrans}, {30'd0, HTRANS_NONSEQ});
    check_eq("c1_haddr", haddr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("c2_haddr", haddr, 32'h4);
    check_eq("c2_valid", {31'd0, ivalid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("c3_valid", {31'd0, ivalid}, 32'd1);
    check_eq("c3_instr", instr, 32'h0);
    check_eq("c3_haddr", haddr, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("c4_instr", instr, 32'h4);

    // Wait states on the address phase of 0x10.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check_eq("ws_htrans", {30'd0, htrans}, {30'd0, HTRANS_NONSEQ});
      check_eq("ws_haddr", haddr, 32'h10);
      check_eq("ws_adv", {31'd0, adv}, 32'd0);
    end
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Decode stall: buffer fills and issuing stops.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      if (i >= 2) begin
        check_eq("stall_idle", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
        check_eq("stall_valid", {31'd0, ivalid}, 32'd1);
      end
    end
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Flush to 0x100 while the data phase for 0x8 is still open.
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("pre_flush_haddr", haddr, 32'h8);
    step(1'b0, 1'b0, 1'b1, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      if (ivalid) begin
        found = 1'b1;
        check_eq("flush_first_pc", ipc, 32'h100);
      end
    end
    check_eq("flush_delivery", {31'd0, found}, 32'd1);

    // Bus error on the fetch at 0xC.
    do_reset();
    err_addr = 32'hC;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      if (ivalid && ifault) begin
        found = 1'b1;
        check_eq("fault_pc", ipc, 32'hC);
      end
    end
    check_eq("fault_seen", {31'd0, found}, 32'd1);
    repeat (6) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("fault_no_issue", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
    end
    step(1'b1, 1'b0, 1'b1, 32'h200);
    err_addr = 32'hFFFF_FFFF;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      if (htrans == HTRANS_NONSEQ) begin
        found = 1'b1;
        check_eq("refetch_addr", haddr, 32'h200);
      end
    end
    check_eq("refetch_issued", {31'd0, found}, 32'd1);

    // Randomized traffic with a mid-run asynchronous reset.
    do_reset();
    data_xor    = 32'h5A5A_C3C3;
    err_rand_en = 1'b1;
    n_pops      = 0;
    for (int c = 0; c < 2500; c++) begin
      if (c == 1200) do_reset();
      step(($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 5), ($urandom & 32'h0000_FFFC));
    end
    check_eq("liveness", {31'd0, (n_pops > 400)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
